mem_arb_ctrl: RTL
=================

// Module: mem_arb_ctrl
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of the 64x8 lab memory block (save_data/write_en/show_reg/d_in/d_out).
//  Turns simple per-requester read/write commands into the memory's multi-cycle control sequence.
//  Writes stage data in the memory's data register, then commit to RAM. Reads address RAM with show_reg high.
//  Sits between user I/O (switch/button port 0) and the pattern/scan engine (port 1) on the Lab2 FPGA top.
// PARAMETERS
//  ADDR_W   6   RAM address width; memory's d_in carries {zero pad, addr}
//  DATA_W   8   data width; also width of the memory's shared d_in bus
// PORTS
//  clk          in   1        single system clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  req          in   2        per-port request; held high until ack
//  we           in   2        per-port command: 1 = write, 0 = read; sampled with req
//  addr0/addr1  in   ADDR_W   per-port address
//  wdata0/1     in   DATA_W   per-port write data
//  ack          out  2        one-cycle completion pulse to the served port
//  rdata        out  DATA_W   read data; valid only in the cycle ack is high for a read
//  busy         out  1        high in every non-IDLE state
//  mem_save     out  1        to memory save_data
//  mem_we       out  1        to memory write_en
//  mem_show     out  1        to memory show_reg
//  mem_din      out  DATA_W   to memory d_in (data or zero-extended address)
//  mem_dout     in   DATA_W   from memory d_out
//  gnt_cnt0/1   out  16       grant counters (see CONFIGURATION)
// BEHAVIOUR
//  FSM states: IDLE, WR_LOAD, WR_COMMIT, RD, RESP. All outputs are registered.
//  Reset: state=IDLE, ack=0, rdata=0, busy=0, mem_save=0, mem_we=0, mem_show=0, mem_din=0, last_gnt=1, counters=0.
//  IDLE: if any req, pick the winner, latch its we/addr/wdata and port index, and leave IDLE.
//    Next state is WR_LOAD if we, else RD. With no req, stay in IDLE with all mem controls at 0.
//  Arbitration: a single requester always wins. If both request, grant the port != last_gnt.
//    last_gnt updates at grant time. After reset, port 0 wins the first contention.
//  WR_LOAD (1 cyc): mem_save=1, mem_din=wdata.
//  WR_COMMIT (1 cyc): mem_we=1, mem_din={0,addr}. The RAM holds wdata after this edge.
//  RD (1 cyc): mem_show=1, mem_din={0,addr}. rdata<=mem_dout at the end of the cycle (RAM read is combinational).
//  RESP (1 cyc): ack[port]=1 and busy=1. Always return to IDLE; no back-to-back grant from RESP.
//  Latency, req seen in IDLE at cycle T: write ack at T+3, read ack at T+2. A write occupies the memory for 2 cycles.
//  Requester duties: deassert req in the ack cycle or the cycle after.
//    req still high in the IDLE cycle after RESP is a new request.
//  req dropping mid-transaction: the latched command still completes and ack still pulses.
//  rst mid-transaction: abort at that edge. No ack, no mem_we.
//    A WR_LOAD already performed leaves the memory data register loaded but the RAM unchanged.
//  Address bits above ADDR_W in mem_din are always 0. rdata holds its last value outside read-ack cycles.
//  Write side effect: the memory's data register ends holding wdata.
//    With mem_show=0 the memory then displays wdata; this is intended.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: gnt_cnt0/gnt_cnt1 each increment by 1 on every grant to their port.
//    They saturate at 16'hFFFF and clear on rst.
//  MEM_ARB_STATS_EN undefined: the ports remain, tied to 16'h0000, and no counter logic is built.
// STRUCTURE
//  mem_arb_pkg: state encoding localparams, PORT0/PORT1 indices, ADDR_W/DATA_W defaults, CNT_W=16.
//  Sub-module rr_arb2: 2-way round-robin picker.
//    Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt_idx. Purely combinational.
//  Top level: FSM, command latch, mem output registers, optional counters.
// TESTING
//  Write then read: port0 writes 8'hA5 to addr 6'h2A, then reads addr 6'h2A.
//    -> write ack at T+3; mem_save at T+1, mem_we at T+2; read ack at T+2 with rdata=8'hA5.
//  Contention: both ports request reads in the same cycle after reset.
//    -> port0 acked first; port1 granted in the next IDLE; acks never overlap.
//  Fairness: both ports hold req continuously for 8 transactions.
//    -> grants alternate 0,1,0,1...; with stats enabled gnt_cnt0=gnt_cnt1=4.
//  Reset mid-write: assert rst during WR_LOAD of a write of 8'h3C to addr 5 that holds 8'h11.
//    -> no ack; all mem controls 0 next cycle; a later read of addr 5 returns 8'h11.
//  Boundaries: write 8'hFF to addr 63 and 8'h01 to addr 0, then read both.
//    -> 8'hFF and 8'h01; mem_din[7:6]=0 during every address phase.
//  Req drop: port1 drops req in RD -> ack still pulses at T+2; no second transaction follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared widths, port indices and state encoding for the two-port memory arbiter/sequencer.
package mem_arb_pkg;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WR_LOAD   = 3'd1;
   localparam logic [2:0] ST_WR_COMMIT = 3'd2;
   localparam logic [2:0] ST_RD        = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      WR_LOAD   = ST_WR_LOAD,
      WR_COMMIT = ST_WR_COMMIT,
      RD        = ST_RD,
      RESP      = ST_RESP
   } state_t;
endpackage

// File: rtl/mem_arb_if.sv
// Requester-side handshake bundle: per-port commands in, ack/read data/busy back.
interface mem_arb_if
   import mem_arb_pkg::*;
   ();
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   modport slave  (input req, we, addr0, addr1, wdata0, wdata1, output ack, rdata, busy);
   modport master (output req, we, addr0, addr1, wdata0, wdata1, input ack, rdata, busy);
endinterface

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin picker; on contention the port that did not win last time is chosen.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_valid,
   output logic       gnt_idx
);
   always_comb begin
      gnt_valid = |req;
      gnt_idx   = PORT0;
      if (req == 2'b11)
         gnt_idx = ~last_gnt;
      else if (req[1])
         gnt_idx = PORT1;
   end
endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin sequencer turning per-port read/write commands into the lab memory's
// save_data/write_en/show_reg sequence. Define MEM_ARB_STATS_EN to build the grant counters.
//
// state     | meaning
// IDLE      | waiting for a request, mem controls low
// WR_LOAD   | mem_save high, wdata on mem_din (loads memory data register)
// WR_COMMIT | mem_we high, address on mem_din (data register -> RAM)
// RD        | mem_show high, address on mem_din, rdata captured at cycle end
// RESP      | one-cycle ack to the served port
module mem_arb_ctrl
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_arb_if.slave          bus,
   output logic              mem_save,
   output logic              mem_we,
   output logic              mem_show,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [CNT_W-1:0]  gnt_cnt0,
   output logic [CNT_W-1:0]  gnt_cnt1
);
   state_t            state;
   logic              last_gnt;
   logic              port;
   logic [ADDR_W-1:0] cmd_addr;
   logic              gnt_valid;
   logic              gnt_idx;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_arb2 u_arb (
      .req       (bus.req),
      .last_gnt  (last_gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      win_we    = bus.we[gnt_idx];
      win_addr  = (gnt_idx == PORT1) ? bus.addr1  : bus.addr0;
      win_wdata = (gnt_idx == PORT1) ? bus.wdata1 : bus.wdata0;
   end

   // Outputs are set on the transition into the state that owns them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bus.ack   <= 2'b00;
         bus.rdata <= '0;
         bus.busy  <= 1'b0;
         mem_save  <= 1'b0;
         mem_we    <= 1'b0;
         mem_show  <= 1'b0;
         mem_din   <= '0;
         last_gnt  <= PORT1;
         port      <= PORT0;
         cmd_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  port     <= gnt_idx;
                  last_gnt <= gnt_idx;
                  cmd_addr <= win_addr;
                  bus.busy <= 1'b1;
                  if (win_we) begin
                     state    <= WR_LOAD;
                     mem_save <= 1'b1;
                     mem_din  <= win_wdata;
                  end else begin
                     state    <= RD;
                     mem_show <= 1'b1;
                     mem_din  <= DATA_W'(win_addr);
                  end
               end
            end
            WR_LOAD: begin
               state    <= WR_COMMIT;
               mem_save <= 1'b0;
               mem_we   <= 1'b1;
               mem_din  <= DATA_W'(cmd_addr);
            end
            WR_COMMIT: begin
               state   <= RESP;
               mem_we  <= 1'b0;
               mem_din <= '0;
               bus.ack <= (port == PORT1) ? 2'b10 : 2'b01;
            end
            RD: begin
               state     <= RESP;
               mem_show  <= 1'b0;
               mem_din   <= '0;
               bus.rdata <= mem_dout;
               bus.ack   <= (port == PORT1) ? 2'b10 : 2'b01;
            end
            RESP: begin
               state    <= IDLE;
               bus.ack  <= 2'b00;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_STATS_EN
   // Saturating per-port grant counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (state == IDLE && gnt_valid) begin
         if (gnt_idx == PORT0 && gnt_cnt0 != '1)
            gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
         if (gnt_idx == PORT1 && gnt_cnt1 != '1)
            gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
   end
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif
endmodule
